// File: rtl/m_lod_pipe_pkg.sv
// Shared definitions for the pipelined leading-one detector: width helpers
// and the parameter legality rule checked at elaboration.
package m_lod_pipe_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // WL_N must be a power of two in 8..64; F must leave at least the leading one out.
    function automatic bit lod_params_ok(input int wl_n, input int wl_f);
        return (wl_n >= 8) && (wl_n <= 64) && ((wl_n & (wl_n - 1)) == 0)
            && (wl_f >= 1) && (wl_f < wl_n);
    endfunction

endpackage

// File: rtl/m_lod_pipe_tree.sv
// Combinational priority encoder built as a binary tree: each level merges
// pairs of nodes, preferring the upper half when it holds a one.
module m_lod_tree
    import m_lod_pipe_pkg::*;
#(
    parameter  int WL_N = 32,
    localparam int WL_K = clog2(WL_N)
) (
    input  logic [WL_N-1:0] vec,
    output logic [WL_K-1:0] pos,
    output logic            any
);

    for (genvar l = 0; l <= WL_K; l++) begin : g_lvl
        localparam int NODES = WL_N >> l;
        logic [NODES-1:0]      v;
        logic [NODES*WL_K-1:0] ix;

        if (l == 0) begin : g_leaf
            assign v  = vec;
            assign ix = '0;
        end else begin : g_node
            for (genvar j = 0; j < NODES; j++) begin : g_pair
                logic hi;
                assign hi = g_lvl[l-1].v[2*j+1];
                assign v[j] = hi | g_lvl[l-1].v[2*j];
                // Upper child wins; its index gains the bit for this level.
                assign ix[j*WL_K +: WL_K] = hi
                    ? (g_lvl[l-1].ix[(2*j+1)*WL_K +: WL_K] | (WL_K'(1) << (l - 1)))
                    : g_lvl[l-1].ix[(2*j)*WL_K +: WL_K];
            end
        end
    end

    assign any = g_lvl[WL_K].v[0];
    assign pos = g_lvl[WL_K].ix;

endmodule

// File: rtl/m_lod_pipe.sv
// Two-stage leading-one detector: S1 takes |N| and its characteristic,
// S2 normalises to a left-justified fraction with sticky, under valid/ready.
module m_lod_pipe
    import m_lod_pipe_pkg::*;
#(
    parameter  int WL_N   = 32,
    parameter  int WL_F   = 8,
    parameter  int SIGNED = 0,
    localparam int WL_K   = clog2(WL_N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL_N-1:0] N,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WL_K-1:0] K,
    output logic [WL_F-1:0] F,
    output logic            sticky,
    output logic            zero,
    output logic            sign
);

    if (!lod_params_ok(WL_N, WL_F)) begin : g_param_check
        $fatal(1, "m_lod_pipe: WL_N must be a power of two in 8..64 and 1 <= WL_F < WL_N");
    end

    logic            v1, v2, adv1, adv2;
    logic            neg;
    logic [WL_N-1:0] mag_in, mag1;
    logic [WL_K-1:0] pos, k1;
    logic            any, zero1, sign1;
    logic [WL_K-1:0] shamt;
    logic [WL_N-2:0] sh;
    logic [WL_F-1:0] f_nxt;
    logic            sticky_nxt;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Unsigned negate maps -2^(WL_N-1) onto 2^(WL_N-1), which fits the field.
    assign neg    = (SIGNED != 0) && N[WL_N-1];
    assign mag_in = neg ? ('0 - N) : N;

    m_lod_tree #(.WL_N(WL_N)) u_tree (
        .vec (mag_in),
        .pos (pos),
        .any (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mag1  <= '0;
            k1    <= '0;
            zero1 <= 1'b0;
            sign1 <= 1'b0;
        end else if (adv1) begin
            v1    <= in_valid;
            mag1  <= mag_in;
            k1    <= pos;
            zero1 <= !any;
            sign1 <= neg;
        end
    end

    // The leading one lands at bit WL_N-1 and is dropped by the truncation.
    assign shamt = WL_K'(WL_N - 1) - k1;
    assign sh    = (WL_N-1)'(mag1 << shamt);
    assign f_nxt = sh[WL_N-2 -: WL_F];

    if (WL_F == WL_N - 1) begin : g_no_sticky
        assign sticky_nxt = 1'b0;
    end else begin : g_sticky
        assign sticky_nxt = |sh[WL_N-2-WL_F:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            K      <= '0;
            F      <= '0;
            sticky <= 1'b0;
            zero   <= 1'b0;
            sign   <= 1'b0;
        end else if (adv2) begin
            v2     <= v1;
            K      <= k1;
            F      <= f_nxt;
            sticky <= sticky_nxt;
            zero   <= zero1;
            sign   <= sign1;
        end
    end

endmodule

// File: tb/tb_m_lod_pipe.sv
// Bench for m_lod_pipe: directed cases at WL_N=32 plus a randomized sweep
// across several widths against an arithmetic reference model.
module tb_m_lod_pipe;

    typedef struct packed {
        logic [6:0]  k;
        logic [63:0] f;
        logic        st;
        logic        z;
        logic        sg;
    } res_t;

    function automatic int wln_of(input int g);
        case (g)
            0, 1:    return 32;
            2:       return 8;
            3:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int wlf_of(input int g);
        case (g)
            0, 1:    return 8;
            2:       return 7;
            3:       return 5;
            default: return 8;
        endcase
    endfunction

    function automatic bit sgn_of(input int g);
        return g == 1;
    endfunction

    // Reference: magnitude, floor(log2), remainder below the leading one scaled to WL_F bits.
    function automatic res_t model(input logic [63:0] n_in, input int wln, input int wlf, input bit sgn);
        logic [63:0] mask, n, mag, rem;
        int          k;
        res_t        r;
        r    = '0;
        mask = (wln == 64) ? '1 : ((64'd1 << wln) - 64'd1);
        n    = n_in & mask;
        if (sgn && n[wln-1]) begin
            r.sg = 1'b1;
            mag  = mask - n + 64'd1;
        end else begin
            mag = n;
        end
        if (mag == 64'd0) begin
            r.z = 1'b1;
            return r;
        end
        k = 0;
        while ((mag >> k) > 64'd1) k++;
        rem = mag - (64'd1 << k);
        if (k >= wlf) begin
            r.f  = rem >> (k - wlf);
            r.st = (rem & ((64'd1 << (k - wlf)) - 64'd1)) != 64'd0;
        end else begin
            r.f = rem << (wlf - k);
        end
        r.k = 7'(k);
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] n_a [5];
    logic        ir_a [5];
    logic        ov_a [5];
    res_t        obs_a [5];

    int          vectors = 0;
    int          miscompares = 0;
    res_t        q [5][$];
    logic        held [5];
    res_t        held_val [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W  = wln_of(g);
        localparam int FW = wlf_of(g);
        localparam int S  = sgn_of(g) ? 1 : 0;
        localparam int KW = $clog2(W);
        logic [KW-1:0] k;
        logic [FW-1:0] f;
        logic          ir, ov, st, z, sg;

        m_lod_pipe #(.WL_N(W), .WL_F(FW), .SIGNED(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir),
            .N         (n_a[g][W-1:0]),
            .out_valid (ov),
            .out_ready (out_ready),
            .K         (k),
            .F         (f),
            .sticky    (st),
            .zero      (z),
            .sign      (sg)
        );

        assign ir_a[g]  = ir;
        assign ov_a[g]  = ov;
        assign obs_a[g] = {7'(k), 64'(f), st, z, sg};
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic chk(input string tag, input int i, input int k, input logic [63:0] f,
                       input bit st, input bit z, input bit sg);
        res_t w;
        w = {7'(k), f, st, z, sg};
        check(tag, 80'({ov_a[i], obs_a[i]}), 80'({1'b1, w}));
    endtask

    task automatic send(input logic [63:0] x);
        for (int i = 0; i < 5; i++) n_a[i] = x;
        in_valid = 1'b1;
        check("accept_ready", 80'(ir_a[0]), 80'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard on the falling edge: order, content and hold-stability for every instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                q[i].delete();
                held[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (held[i])
                    check($sformatf("hold_u%0d", i), 80'({ov_a[i], obs_a[i]}), 80'({1'b1, held_val[i]}));
                if (ov_a[i] && out_ready) begin
                    if (q[i].size() == 0)
                        check($sformatf("unexpected_out_u%0d", i), 80'(ov_a[i]), 80'(0));
                    else
                        check($sformatf("result_u%0d", i), 80'(obs_a[i]), 80'(q[i].pop_front()));
                end
                if (in_valid && ir_a[i])
                    q[i].push_back(model(n_a[i], wln_of(i), wlf_of(i), sgn_of(i)));
                held[i]     = ov_a[i] && !out_ready;
                held_val[i] = obs_a[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        int unsigned sel;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_a[i]  = '0;
            held[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        check("reset_u0", 80'({ov_a[0], obs_a[0]}), 80'(0));
        check("reset_u1", 80'({ov_a[1], obs_a[1]}), 80'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_after_reset", 80'(ir_a[0]), 80'(1));

        send(64'h0);
        check("latency_not_early", 80'(ov_a[0]), 80'(0));
        @(posedge clk); #1;
        chk("zero", 0, 0, 64'h0, 1'b0, 1'b1, 1'b0);
        send(64'h1);
        @(posedge clk); #1;
        chk("one", 0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
        send(64'h0000_0B00);
        @(posedge clk); #1;
        chk("frac_b00", 0, 11, 64'h60, 1'b0, 1'b0, 1'b0);
        send(64'h8000_0001);
        @(posedge clk); #1;
        chk("sticky_u", 0, 31, 64'h00, 1'b1, 1'b0, 1'b0);
        chk("sticky_s", 1, 30, 64'hFF, 1'b1, 1'b0, 1'b1);
        send(64'h0000_00FF);
        @(posedge clk); #1;
        chk("ff_w32", 0, 7, 64'hFE, 1'b0, 1'b0, 1'b0);
        chk("ff_w8_fullfrac", 2, 7, 64'h7F, 1'b0, 1'b0, 1'b0);
        send(64'hFFFF_FFF0);
        @(posedge clk); #1;
        chk("signed_neg16", 1, 4, 64'h0, 1'b0, 1'b0, 1'b1);
        send(64'h8000_0000);
        @(posedge clk); #1;
        chk("signed_min", 1, 31, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("unsigned_msb", 0, 31, 64'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: two results buffer, then the input stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) n_a[i] = 64'h1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_one_held", 80'(ir_a[0]), 80'(1));
        for (int i = 0; i < 5; i++) n_a[i] = 64'h2;
        @(posedge clk); #1;
        check("bp_ready_full", 80'(ir_a[0]), 80'(0));
        for (int i = 0; i < 5; i++) n_a[i] = 64'h4;
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full", 80'(ir_a[0]), 80'(0));
        chk("bp_hold_k0", 0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_k0", 0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
        check("bp_ready_release", 80'(ir_a[0]), 80'(1));
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) n_a[i] = 64'h8;
        @(negedge clk);
        chk("bp_k1", 0, 1, 64'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_k2", 0, 2, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_k3", 0, 3, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_no_dup", 80'(ov_a[0]), 80'(0));
        @(posedge clk); #1;

        // Reset with both stages full, asserted mid-cycle.
        out_ready = 1'b0;
        send(64'h5);
        send(64'h7);
        chk("pre_reset_full", 0, 2, 64'h40, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_u0", 80'({ov_a[0], obs_a[0]}), 80'(0));
        check("reset_async_u1", 80'({ov_a[1], obs_a[1]}), 80'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_after_midreset", 80'(ir_a[0]), 80'(1));
        out_ready = 1'b1;
        send(64'h10);
        check("no_stale_result", 80'(ov_a[0]), 80'(0));
        @(posedge clk); #1;
        chk("after_reset_k4", 0, 4, 64'h0, 1'b0, 1'b0, 1'b0);

        // Random sweep across all widths with random valid/ready.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            for (int i = 0; i < 5; i++) begin
                r   = {$urandom, $urandom};
                sel = $urandom % 8;
                if (sel == 0)      n_a[i] = '0;
                else if (sel == 1) n_a[i] = 64'd1 << ($urandom % 64);
                else               n_a[i] = r >> ($urandom % 64);
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            check($sformatf("drained_u%0d", i), 80'(q[i].size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_lod_pipe.md
# m_lod_pipe

Parametrised, pipelined leading-one detector for the logarithmic-arithmetic datapath. It replaces the fixed 32-bit combinational characteristic ROM with a WL_N-bit, two-stage registered block. Besides the characteristic K, it produces:
- a left-justified fractional part (Mitchell mantissa);
- a sticky bit;
- an explicit zero flag;
- optional two's-complement magnitude handling.

Valid/ready handshakes on both sides let it sit between the operand registers and the log-domain adder.

## Interface
- WL_N, 32: input wordlength; power of two, 8..64.
- WL_K, clog2(WL_N): characteristic width; derived, not overridden.
- WL_F, 8: fraction output width; 1..WL_N-1.
- SIGNED, 0: 0 = N unsigned; 1 = N two's complement, detection on |N|.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  N is valid this cycle.
- in_ready  output  1  block accepts N this cycle.
- N  input  WL_N  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- K  output  WL_K  index of leading one of magnitude.
- F  output  WL_F  bits below the leading one, left-justified, truncated.
- sticky  output  1  OR of magnitude bits below the leading one that were dropped from F.
- zero  output  1  magnitude == 0.
- sign  output  1  input sign; always 0 when SIGNED=0.

## Operation
- Transfer occurs on a side when valid && ready are both high at a rising clk.
- Stage 1 (S1) registers:
  - mag = SIGNED ? abs(N) : N, held as an unsigned WL_N-bit value.
  - The abs of -2^(WL_N-1) is 2^(WL_N-1), which fits the unsigned field.
  - sign = SIGNED & N[WL_N-1].
  - K = position of the highest set bit of mag, from the priority-encoder sub-module.
  - zero = (mag == 0).
- Stage 2 (S2) registers:
  - sh = mag << (WL_N-1-K), so the leading one lands at bit WL_N-1.
  - F = sh[WL_N-2 -: WL_F].
  - sticky = |sh[WL_N-2-WL_F : 0], or 0 when WL_F = WL_N-1.
  - K, zero and sign are forwarded unchanged.
- mag == 0 gives K=0, F=0, sticky=0, zero=1.
- mag == 1 gives K=0, F=0, sticky=0, zero=0. The zero flag is the only way to tell these two cases apart.
- Stage control, where v1/v2 are the stage valid bits:
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - in_ready = adv1
  - out_valid = v2
- S2 loads from S1 when adv2; v2 <= v1 on that edge.
- S1 loads N when adv1; v1 <= in_valid on that edge.
- Payload registers load only when their stage advances. Outputs are stable while out_valid && !out_ready.
- No combinational path from out_ready to K, F, sticky, zero or sign. in_ready does depend combinationally on out_ready.

## Timing
- Latency: 2 cycles. N accepted at edge t appears at the outputs after edge t+1, and is consumable at edge t+2.
- Throughput: 1 result per cycle while out_ready stays high.
- Backpressure:
  - With out_ready low, 2 results are buffered (S1, S2). in_ready falls on the cycle both stages are valid.
  - No drop, duplication or reordering.
- Simultaneous accept and emit with the pipeline full and out_ready high: S2 takes S1 and S1 takes the new N in the same edge.
- Reset (asynchronous assert, any time, including mid-transfer):
  - v1 = v2 = 0, out_valid = 0.
  - K=0, F=0, sticky=0, zero=0, sign=0.
  - in_ready = 1 while rst_n is high and the pipe is empty.
  - In-flight data is discarded.
- Reset deassertion is synchronised externally. The first transfer can occur on the first edge after release.

## Structure
- Shared package/header holds:
  - the clog2 constant function;
  - the WL_N legality check, which stops elaboration for a non-power-of-two WL_N or WL_F >= WL_N.
- Sub-module m_lod_tree: combinational, parametrised priority encoder (WL_N -> WL_K plus any-one flag). It is built as a log2(WL_N)-level binary tree, not a casex table. It is reused by the normaliser.
- The top level holds the abs, the two register stages, the barrel shift and the handshake.

## Test plan
All scenarios use WL_N=32, WL_F=8 unless stated.
- **Zero and one.** N=0 -> K=0, zero=1, F=0, sticky=0. N=1 -> K=0, zero=0, F=0, sticky=0. Each appears 2 cycles after acceptance.
- **Fraction and sticky.** N=32'h0000_0B00 -> K=11, F=8'h60, sticky=0. N=32'h8000_0001 -> K=31, F=8'h00, sticky=1.
- **Signed mode (SIGNED=1).**
  - N=32'hFFFF_FFF0 -> sign=1, K=4, F=0, zero=0.
  - N=32'h8000_0000 -> sign=1, K=31, F=0, sticky=0.
- **Backpressure.**
  - Stimulus: stream 32'h1, 32'h2, 32'h4, 32'h8 with out_ready held low.
  - Expected: two accepted, then in_ready=0.
  - After out_ready rises, outputs K=0,1,2,3 in order with no gaps or duplicates.
- **Reset mid-stream.** Assert rst_n low with both stages valid -> out_valid=0 and all outputs 0 immediately. The next accepted N=32'h10 -> K=4 with no stale result emitted.
- **Sweep.** Random N with random valid/ready at WL_N=8, 16, 64 -> K, F, sticky and zero match the reference model, and handshake invariants hold.
